// File: rtl/ir_queue.sv
// ir_queue: in-order instruction fetch queue with first-word fall-through head and a held instruction register
module ir_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DATA_W-1:0]          ir_o,
  output logic                       ir_valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic              w_push, w_pop;
  assign wr_ready_o = r_count != FULL;
  assign rd_valid_o = r_count != '0;
  assign rd_data_o  = r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign ir_o       = r_ir;
  assign ir_valid_o = r_ir_valid;
  assign w_push     = wr_valid_i & wr_ready_o & ~flush_i;
  assign w_pop      = rd_ready_i & rd_valid_o & ~flush_i;
  // storage is deliberately unreset; only the written slot changes
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
  end
  // pointers and occupancy; flush wins over any same-cycle push or pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // instruction register captures the head on pop and holds otherwise; flush only invalidates it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else if (flush_i) begin
      r_ir_valid <= 1'b0;
    end else if (w_pop) begin
      r_ir       <= rd_data_o;
      r_ir_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed scoreboard bench for ir_queue
module tb_ir_queue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_n, flush, wv, rr;
  logic [31:0] wd;
  logic        wrdy, rvld, irv;
  logic [31:0] rdat, ir;
  logic [2:0]  cnt;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mq[$];
  logic [31:0] m_ir;
  logic        m_irv;

  ir_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .wr_valid_i(wv), .wr_ready_o(wrdy), .wr_data_i(wd),
    .rd_ready_i(rr), .rd_valid_o(rvld), .rd_data_o(rdat),
    .count_o(cnt), .ir_o(ir), .ir_valid_o(irv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string t);
    chk({t, ".count"}, 32'(cnt), 32'(mq.size()));
    chk({t, ".rd_valid"}, 32'(rvld), 32'(mq.size() != 0));
    chk({t, ".wr_ready"}, 32'(wrdy), 32'(mq.size() != DEPTH));
    if (mq.size() != 0) chk({t, ".rd_data"}, rdat, mq[0]);
    chk({t, ".ir"}, ir, m_ir);
    chk({t, ".ir_valid"}, 32'(irv), 32'(m_irv));
  endtask

  task automatic cycle(input string t, input logic w, input logic [31:0] d, input logic r, input logic f);
    @(negedge clk);
    wv = w; wd = d; rr = r; flush = f;
    #1 check_state(t);
    if (f) begin
      mq.delete();
      m_irv = 1'b0;
    end else begin
      logic do_pop, do_push;
      do_pop  = r && mq.size() != 0;
      do_push = w && mq.size() != DEPTH;
      if (do_pop) begin
        m_ir  = mq.pop_front();
        m_irv = 1'b1;
      end
      if (do_push) mq.push_back(d);
    end
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] fill [4];
    fill[0] = 32'h00000013; fill[1] = 32'h00100093;
    fill[2] = 32'h00200113; fill[3] = 32'h00300193;
    rst_n = 1'b0; flush = 1'b0; wv = 1'b0; rr = 1'b0; wd = '0;
    m_ir = '0; m_irv = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_state("reset");
    @(negedge clk) rst_n = 1'b1;
    // latency into an empty queue
    cycle("lat_push", 1, 32'h11111111, 0, 0);
    cycle("lat_seen", 0, 0, 1, 0);
    cycle("lat_empty", 0, 0, 0, 0);
    // fill to full, then offer a word that must be refused
    for (int i = 0; i < 4; i++) cycle("fill", 1, fill[i], 0, 0);
    repeat (3) cycle("full_hold", 1, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 4; i++) cycle("drain", 0, 0, 1, 0);
    cycle("drained", 0, 0, 1, 0);
    chk("drain_last_ir", m_ir, fill[3]);
    // steady count=2 with simultaneous push/pop across pointer wrap
    cycle("wrap_pre0", 1, 32'hA0000000, 0, 0);
    cycle("wrap_pre1", 1, 32'hA0000001, 0, 0);
    for (int i = 2; i < 12; i++) cycle("wrap", 1, 32'hA0000000 + 32'(i), 1, 0);
    repeat (2) cycle("wrap_drain", 0, 0, 1, 0);
    // instruction register hold while the queue refills
    cycle("hold_push", 1, 32'h00A00513, 0, 0);
    cycle("hold_pop", 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle("hold", 1, 32'hB0000000 + 32'(i), 0, 0);
    cycle("hold_end", 0, 0, 0, 0);
    // flush priority over a same-cycle push and pop
    cycle("fl_clr", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("fl_fill", 1, 32'hC0000000 + 32'(i), 0, 0);
    cycle("flush", 1, 32'hF00DF00D, 1, 1);
    cycle("post_flush", 1, 32'hCAFE0001, 0, 0);
    cycle("post_flush_pop", 0, 0, 1, 0);
    cycle("post_flush_end", 0, 0, 0, 0);
    // asynchronous reset mid-stream with 3 words queued
    for (int i = 0; i < 3; i++) cycle("rst_fill", 1, 32'hD0000000 + 32'(i), 0, 0);
    @(negedge clk);
    wv = 1'b0; rr = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst.count", 32'(cnt), 0);
    chk("async_rst.rd_valid", 32'(rvld), 0);
    chk("async_rst.wr_ready", 32'(wrdy), 1);
    chk("async_rst.ir", ir, 0);
    chk("async_rst.ir_valid", 32'(irv), 0);
    mq.delete(); m_ir = '0; m_irv = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cycle("after_rst", 1, 32'hE0000001, 0, 0);
    cycle("after_rst_pop", 0, 0, 1, 0);
    cycle("after_rst_end", 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
